variable_node_sat: RTL



---
 rtl/variable_node_sat.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/variable_node_sat.sv
`default_nettype none
// ============================================================================
// Module   : variable_node_sat
// Purpose  : Min-sum LDPC variable node. Snapshots all check-to-variable
//            messages, serially sums them with the stored channel LLR, then
//            emits the saturated posterior, the hard decision and the per-edge
//            extrinsic messages (total minus own edge).
// Revision : 1.0 - initial release
// ============================================================================
module variable_node_sat #(
  parameter int WEIGHT = 3,
  parameter int MSG_W  = 8,
  parameter int ACC_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,                // asynchronous, active-low
  input  logic                    init_valid,
  input  logic [MSG_W-1:0]        initial_value,
  input  logic [WEIGHT*MSG_W-1:0] check_value_input,
  input  logic [WEIGHT-1:0]       check_enable_input,
  input  logic                    decision_down,
  output logic [WEIGHT*MSG_W-1:0] extrinsic_out,
  output logic [MSG_W-1:0]        variable_value,
  output logic                    hard_bit,
  output logic                    variable_enable,
  output logic                    busy
);

  localparam int CNT_W = (WEIGHT > 1) ? $clog2(WEIGHT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WEIGHT - 1);

  // Symmetric clamp bounds: the most negative code is never produced.
  localparam logic signed [ACC_W:0] C_SAT_HI = (ACC_W+1)'((1 <<< (MSG_W-1)) - 1);
  localparam logic signed [ACC_W:0] C_SAT_LO = -C_SAT_HI;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUM  = 2'd1,
    S_EMIT = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MSG_W-1:0]          ch_q, ch_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [MSG_W-1:0]          msg_q [WEIGHT];
  logic [MSG_W-1:0]          msg_d [WEIGHT];
  logic [MSG_W-1:0]          val_q, val_d;
  logic                      hard_q, hard_d;
  logic [WEIGHT*MSG_W-1:0]   extr_q, extr_d;
  logic                      ven_q, ven_d;

  // Sign-extend a message to accumulator width.
  function automatic logic [ACC_W-1:0] sext_acc(input logic [MSG_W-1:0] m);
    return {{(ACC_W-MSG_W){m[MSG_W-1]}}, m};
  endfunction

  // Sign-extend a message to one bit beyond the accumulator, for subtraction.
  function automatic logic signed [ACC_W:0] sext_wide(input logic [MSG_W-1:0] m);
    return {{(ACC_W+1-MSG_W){m[MSG_W-1]}}, m};
  endfunction

  // Clamp a wide signed value into the symmetric message range.
  function automatic logic [MSG_W-1:0] sat_w(input logic signed [ACC_W:0] v);
    if (v > C_SAT_HI) begin
      return C_SAT_HI[MSG_W-1:0];
    end else if (v < C_SAT_LO) begin
      return C_SAT_LO[MSG_W-1:0];
    end else begin
      return v[MSG_W-1:0];
    end
  endfunction

  // Next-state and datapath: snapshot, serial accumulate, emit, handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    msg_d   = msg_q;
    val_d   = val_q;
    hard_d  = hard_q;
    extr_d  = extr_q;
    ven_d   = ven_q;
    case (state_q)
      S_IDLE: begin
        if (init_valid) begin
          ch_d = initial_value;
        end
        if (&check_enable_input) begin
          for (int i = 0; i < WEIGHT; i++) begin
            msg_d[i] = check_value_input[i*MSG_W +: MSG_W];
          end
          // A channel value arriving on the capture edge takes effect now.
          acc_d   = sext_acc(init_valid ? initial_value : ch_q);
          cnt_d   = '0;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        acc_d = acc_q + sext_acc(msg_q[cnt_q]);
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        val_d  = sat_w({acc_q[ACC_W-1], acc_q});
        hard_d = acc_q[ACC_W-1];
        for (int i = 0; i < WEIGHT; i++) begin
          extr_d[i*MSG_W +: MSG_W] =
            sat_w($signed({acc_q[ACC_W-1], acc_q}) - sext_wide(msg_q[i]));
        end
        ven_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (decision_down) begin
          ven_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      for (int i = 0; i < WEIGHT; i++) begin
        msg_q[i] <= '0;
      end
      val_q   <= '0;
      hard_q  <= 1'b0;
      extr_q  <= '0;
      ven_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      msg_q   <= msg_d;
      val_q   <= val_d;
      hard_q  <= hard_d;
      extr_q  <= extr_d;
      ven_q   <= ven_d;
    end
  end

  assign extrinsic_out   = extr_q;
  assign variable_value  = val_q;
  assign hard_bit        = hard_q;
  assign variable_enable = ven_q;
  assign busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire
